// File: rtl/chess_pkg.sv
// Shared chess definitions: piece codes, change-piece field layout and
// write-sequencer state encodings.
package chess_pkg;

    typedef enum logic [3:0] {
        WHITE_EMPTY  = 4'b0000,
        WHITE_KING   = 4'b0001,
        WHITE_QUEEN  = 4'b0010,
        WHITE_BISHOP = 4'b0011,
        WHITE_KNIGHT = 4'b0100,
        WHITE_ROOK   = 4'b0101,
        WHITE_PAWN   = 4'b0110,
        BLACK_EMPTY  = 4'b1000,
        BLACK_KING   = 4'b1001,
        BLACK_QUEEN  = 4'b1010,
        BLACK_BISHOP = 4'b1011,
        BLACK_KNIGHT = 4'b1100,
        BLACK_ROOK   = 4'b1101,
        BLACK_PAWN   = 4'b1110
    } piece_t;

    localparam int SQ_W           = 6;
    localparam int PIECE_W        = 4;
    localparam int SLOT_W         = SQ_W + PIECE_W;
    localparam int CP_ADDR_LSB    = 0;
    localparam int CP_CONTENT_LSB = 6;
    localparam int CP_WE_BIT      = 10;
    localparam int CP_W           = 11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_MOVE = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Back-rank piece for a column, white colour; black differs only in bit 3.
    function automatic piece_t white_back_rank(input logic [2:0] col);
        case (col)
            3'd0, 3'd7: return WHITE_ROOK;
            3'd1, 3'd6: return WHITE_KNIGHT;
            3'd2, 3'd5: return WHITE_BISHOP;
            3'd3:       return WHITE_QUEEN;
            default:    return WHITE_KING;
        endcase
    endfunction

endpackage

// File: rtl/start_position_rom.sv
// Combinational starting-position lookup: square index (column*8 + row) to
// the 4-bit piece code placed there at the start of a game.
module start_position_rom
    import chess_pkg::*;
(
    input  logic [SQ_W-1:0]    square,
    output logic [PIECE_W-1:0] content
);

    logic [2:0] col;
    logic [2:0] row;
    piece_t     back;

    assign col = square[5:3];
    assign row = square[2:0];

    always_comb begin
        back    = white_back_rank(col);
        content = WHITE_EMPTY;
        case (row)
            3'd0:    content = back | 4'b1000;
            3'd1:    content = BLACK_PAWN;
            3'd6:    content = WHITE_PAWN;
            3'd7:    content = back;
            default: content = WHITE_EMPTY;
        endcase
    end

endmodule

// File: rtl/board_write_sequencer.sv
// Serialises multi-square move commands and full-board initialisation into
// one change-piece write per cycle; initialisation has priority.
module board_write_sequencer
    import chess_pkg::*;
#(
    parameter int MAX_WRITES    = 4,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       init_req,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_count,
    input  logic [SLOT_W*MAX_WRITES-1:0] cmd_data,
    output logic [CP_W-1:0]            change_piece,
    output logic                       busy,
    output logic                       done,
    output logic                       init_done
);

    localparam int IW = 3;

    state_t                           state;
    logic [SQ_W-1:0]                  square;
    logic                             init_last;
    logic                             pending;
    logic                             boot;
    logic [MAX_WRITES-1:0][SLOT_W-1:0] slots;
    logic [IW-1:0]                    count;
    logic [IW-1:0]                    index;
    logic [IW-1:0]                    count_clamped;
    logic [SLOT_W-1:0]                slot_sel;
    logic [PIECE_W-1:0]               rom_content;
    logic                             accept;

    start_position_rom u_rom (
        .square  (square),
        .content (rom_content)
    );

    // boot stands in for an init request raised by reset itself
    assign cmd_ready = !reset && (state == S_IDLE) && !init_req && !pending && !boot;
    assign busy      = (state != S_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    assign count_clamped = (cmd_count > IW'(MAX_WRITES)) ? IW'(MAX_WRITES) : cmd_count;

    always_comb begin
        slot_sel = slots[0];
        for (int k = 0; k < MAX_WRITES; k++)
            if (index == IW'(k)) slot_sel = slots[k];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            square       <= '0;
            init_last    <= 1'b0;
            pending      <= 1'b0;
            boot         <= INIT_ON_RESET;
            slots        <= '0;
            count        <= '0;
            index        <= '0;
            change_piece <= '0;
            done         <= 1'b0;
            init_done    <= 1'b0;
        end else begin
            done      <= 1'b0;
            init_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    change_piece[CP_WE_BIT] <= 1'b0;
                    if (init_req || boot) begin
                        state     <= S_INIT;
                        square    <= '0;
                        init_last <= 1'b0;
                        pending   <= 1'b0;
                        boot      <= 1'b0;
                    end else if (accept) begin
                        slots <= cmd_data;
                        count <= count_clamped;
                        index <= '0;
                        state <= (count_clamped == '0) ? S_DONE : S_MOVE;
                    end
                end
                S_INIT: begin
                    // one extra cycle after square 63 so init_done trails the last write
                    if (!init_last) begin
                        change_piece[CP_WE_BIT]                    <= 1'b1;
                        change_piece[CP_CONTENT_LSB +: PIECE_W]    <= rom_content;
                        change_piece[CP_ADDR_LSB +: SQ_W]          <= square;
                        if (square == 6'd63) init_last <= 1'b1;
                        else                 square    <= square + 6'd1;
                    end else begin
                        change_piece[CP_WE_BIT] <= 1'b0;
                        init_done               <= 1'b1;
                        init_last               <= 1'b0;
                        state                   <= S_IDLE;
                    end
                end
                S_MOVE: begin
                    if (init_req) pending <= 1'b1;
                    change_piece[CP_WE_BIT]    <= 1'b1;
                    change_piece[SLOT_W-1:0]   <= slot_sel;
                    index                      <= index + IW'(1);
                    if (index == count - IW'(1)) state <= S_DONE;
                end
                S_DONE: begin
                    // two cycles: first raises done, second hands off
                    if (init_req) pending <= 1'b1;
                    change_piece[CP_WE_BIT] <= 1'b0;
                    if (!done) begin
                        done <= 1'b1;
                    end else if (pending || init_req) begin
                        state     <= S_INIT;
                        square    <= '0;
                        init_last <= 1'b0;
                        pending   <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_write_sequencer.sv
// Randomised self-checking bench for board_write_sequencer against a
// behavioural model of init loads and move-command write order.
module tb_board_write_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        init_req;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_count;
    logic [39:0] cmd_data;
    logic [10:0] change_piece;
    logic        busy;
    logic        done;
    logic        init_done;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [9:0]  last_cp;
    logic [3:0]  obs_board [64];

    always #5 clk = ~clk;

    board_write_sequencer #(.MAX_WRITES(4), .INIT_ON_RESET(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .init_req     (init_req),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_count    (cmd_count),
        .cmd_data     (cmd_data),
        .change_piece (change_piece),
        .busy         (busy),
        .done         (done),
        .init_done    (init_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference starting position from the board layout rules
    function automatic logic [3:0] start_sq(input int idx);
        int br [8];
        int col;
        int row;
        br  = '{5, 4, 3, 2, 1, 3, 4, 5};
        col = idx / 8;
        row = idx % 8;
        case (row)
            0:       return 4'(8 + br[col]);
            1:       return 4'd14;
            6:       return 4'd6;
            7:       return 4'(br[col]);
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [9:0] slot(input logic [3:0] c, input logic [5:0] a);
        return {c, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Next posedge enters INIT; check writes up to stop_at (-1 = full load)
    task automatic expect_init(input int stop_at, input bit pulse_ignored);
        int seen = 0;
        int pk   = $urandom_range(5, 50);
        tick();
        init_req  = 1'b0;
        cmd_valid = 1'b0;
        chk("init_busy", 32'(busy), 32'd1);
        chk("init_ready", 32'(cmd_ready), 32'd0);
        for (int k = 0; k < 64; k++) begin
            if (pulse_ignored) init_req = (k == pk);
            tick();
            chk("init_wr", 32'(change_piece), 32'({1'b1, start_sq(k), 6'(k)}));
            obs_board[k] = change_piece[9:6];
            if (init_done) seen++;
            if (k == stop_at) begin
                init_req = 1'b0;
                return;
            end
        end
        init_req = 1'b0;
        last_cp  = {start_sq(63), 6'd63};
        tick();
        chk("init_done", 32'(init_done), 32'd1);
        chk("init_we_off", 32'(change_piece[10]), 32'd0);
        chk("init_hold", 32'(change_piece[9:0]), 32'(last_cp));
        chk("init_done_early", seen, 0);
        chk("init_ready_after", 32'(cmd_ready), 32'd1);
    endtask

    // Issue one command from IDLE; init_at >= 0 pulses init_req during write
    // init_at (or during the done cycle when init_at == number of writes)
    task automatic do_move(input logic [2:0] cnt, input logic [39:0] data, input int init_at);
        int         n = (cnt > 3'd4) ? 4 : int'(cnt);
        logic [9:0] q [$];
        for (int k = 0; k < n; k++) q.push_back(data[10*k +: 10]);
        chk("mv_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_count = cnt;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
        cmd_count = 3'($urandom());
        cmd_data  = 40'({$urandom(), $urandom()});
        chk("mv_busy", 32'(busy), 32'd1);
        for (int k = 0; k < n; k++) begin
            init_req = (init_at == k);
            tick();
            chk("mv_wr", 32'(change_piece), 32'({1'b1, q[k]}));
            chk("mv_ready_low", 32'(cmd_ready), 32'd0);
            last_cp = q[k];
        end
        init_req = (init_at == n);
        tick();
        init_req = 1'b0;
        chk("mv_done", 32'(done), 32'd1);
        chk("mv_we_off", 32'(change_piece[10]), 32'd0);
        chk("mv_hold", 32'(change_piece[9:0]), 32'(last_cp));
        if (init_at >= 0) begin
            expect_init(-1, 1'b0);
        end else begin
            tick();
            chk("mv_done_pulse", 32'(done), 32'd0);
            chk("mv_ready_back", 32'(cmd_ready), 32'd1);
        end
    endtask

    initial begin
        logic [2:0]  rc;
        logic [39:0] rd;
        int          rn;
        int          ra;

        reset     = 1'b1;
        init_req  = 1'b0;
        cmd_valid = 1'b0;
        cmd_count = 3'd0;
        cmd_data  = '0;
        last_cp   = '0;
        repeat (2) @(negedge clk);
        chk("rst_cp", 32'(change_piece), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);

        reset = 1'b0;
        expect_init(-1, 1'b1);
        chk("anchor_bk", 32'(obs_board[32]), 32'h9);
        chk("anchor_wk", 32'(obs_board[39]), 32'h1);
        chk("anchor_r0", 32'(obs_board[0]), 32'hd);
        chk("anchor_r56", 32'(obs_board[56]), 32'hd);
        chk("anchor_r7", 32'(obs_board[7]), 32'h5);
        chk("anchor_r63", 32'(obs_board[63]), 32'h5);
        chk("anchor_wp6", 32'(obs_board[6]), 32'h6);
        chk("anchor_e20", 32'(obs_board[20]), 32'h0);

        do_move(3'd2, {20'd0, slot(4'b0110, 6'd44), slot(4'b0000, 6'd46)}, -1);
        do_move(3'd4, {slot(4'b0000, 6'd63), slot(4'b0101, 6'd47),
                       slot(4'b0000, 6'd39), slot(4'b0001, 6'd55)}, -1);

        init_req  = 1'b1;
        cmd_valid = 1'b1;
        cmd_count = 3'd2;
        cmd_data  = 40'({$urandom(), $urandom()});
        #1;
        chk("tie_ready", 32'(cmd_ready), 32'd0);
        expect_init(-1, 1'b0);

        do_move(3'd3, 40'({$urandom(), $urandom()}), 1);
        do_move(3'd0, 40'({$urandom(), $urandom()}), -1);
        do_move(3'd7, 40'({$urandom(), $urandom()}), -1);
        do_move(3'd2, {20'd0, slot(4'b0011, 6'd10), slot(4'b1100, 6'd10)}, -1);

        init_req = 1'b1;
        expect_init(30, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("midrst_cp", 32'(change_piece), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        chk("midrst_cp_hold", 32'(change_piece), 32'd0);
        chk("midrst_ready", 32'(cmd_ready), 32'd0);
        reset = 1'b0;
        expect_init(-1, 1'b0);

        repeat (25) begin
            rc = 3'($urandom_range(0, 7));
            rd = 40'({$urandom(), $urandom()});
            if ($urandom_range(0, 3) == 0) rd[15:10] = rd[5:0];
            rn = (rc > 3'd4) ? 4 : int'(rc);
            ra = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, rn)) : -1;
            do_move(rc, rd, ra);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/board_write_sequencer.md
# board_write_sequencer

Write sequencer and arbiter for the 64-square board store (the build-board memory, 4-bit code per square). It accepts multi-square move commands from the user state machine over a valid/ready handshake and serialises them into one square write per cycle. Commands of up to four writes cover a normal move, a promotion, castling and en passant. It also has a board-initialisation requester that loads the standard starting position, and that requester has priority. Output uses the existing 11-bit change-piece format, so the board store needs no change.

## Interface
Parameters:
- MAX_WRITES, 4, maximum square writes per move command
- INIT_ON_RESET, 1, when 1 an initialisation load starts automatically after reset

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- init_req  in  1  level/pulse request for full starting-position load
- cmd_valid  in  1  move command present
- cmd_ready  out  1  sequencer can accept a command this cycle
- cmd_count  in  3  number of valid slots, 0..4
- cmd_data  in  40  slot k at [10k+9:10k] = {content[3:0], addr[5:0]}; slot 0 issued first
- change_piece  out  11  [5:0] addr, [9:6] content, [10] write enable
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle pulse after the last write of a move command
- init_done  out  1  one-cycle pulse after square 63 is written by init

## Operation
- States: IDLE, INIT, MOVE, DONE.
- IDLE behaviour:
  - cmd_ready = 1 only when init_req = 0 and no init is pending.
  - Accept on cmd_valid && cmd_ready: capture cmd_data and min(cmd_count, MAX_WRITES), clear slot index, go to MOVE.
  - cmd_count = 0 goes directly to DONE with no write.
- init_req in IDLE goes to INIT with the square counter at 0. Init wins over a simultaneous cmd_valid, and that command is not accepted.
- INIT:
  - Each cycle writes square counter → content, then increments. After 63, go to IDLE and pulse init_done.
  - The counter is 6 bits and exits on 63, so it never wraps.
- Starting position, where square index = column·8 + row (column = idx[5:3], row = idx[2:0]):
  - row 0 is black back rank, columns 0..7 = ROOK KNIGHT BISHOP QUEEN KING BISHOP KNIGHT ROOK (1101,1100,1011,1010,1001,1011,1100,1101)
  - row 1 is BLACK_PAWN 1110
  - row 6 is WHITE_PAWN 0110
  - row 7 is the white back rank in the same column order (0101,0100,0011,0010,0001,0011,0100,0101)
  - rows 2..5 are 0000
  - Resulting anchors: black king 32, white king 39, rooks 0/56/7/63.
- MOVE:
  - Each cycle writes slot[index], then increments the index. After slot count−1, go to DONE.
  - Duplicate addresses are written in slot order, so the last slot wins.
- DONE:
  - change_piece[10] = 0 and done = 1 for one cycle.
  - Then go to INIT if an init request was latched during MOVE/DONE, otherwise to IDLE.
- init_req asserted during MOVE or DONE sets a pending flag. The in-flight command always completes. The pending flag clears on entering INIT.
- init_req asserted during INIT is ignored.
- change_piece[10] is 0 in IDLE and DONE.
- change_piece[9:0] holds its last value when not writing.

## Timing
- Reset values:
  - state IDLE
  - change_piece 0
  - cmd_ready 0 during reset
  - busy 0, done 0, init_done 0
  - pending flag 0, counters 0
- With INIT_ON_RESET = 1, the first clock after reset deassert enters INIT. busy = 1 and cmd_ready = 0 from that edge.
- All outputs are registered except cmd_ready and busy, which decode from the state register.
- Move command accepted at edge T:
  - Writes are visible at T+1 .. T+N.
  - done is high in cycle T+N+1.
  - cmd_ready returns in cycle T+N+2.
  - With N = 0, done is high at T+1.
- Init entered at edge T: writes appear at T+1 .. T+64, and init_done is high at T+65.
- Reset asserted mid-operation aborts immediately. A partially written board is acceptable, and init re-runs if INIT_ON_RESET = 1.

## Structure
- Shared package chess_pkg, holding:
  - the 4-bit piece encodings (WHITE_EMPTY 0000 … BLACK_PAWN 1110)
  - the change-piece field offsets
  - the state encodings
- One sub-module, start_position_rom: a combinational function of the 6-bit square index that returns the 4-bit code. Used by INIT and reusable by the verification model.

## Test plan
- Reset with INIT_ON_RESET = 1, then run 66 cycles → 64 writes in address order; square 32 = 1001, 39 = 0001, 0 = 1101, 6 = 0110, 20 = 0000; init_done pulses exactly once, at square 63 write + 1.
- Normal move, count 2, slots {0000@46, 0110@44} → writes addr 46 then addr 44 on consecutive cycles; done one cycle later; cmd_ready low throughout.
- Castle, count 4: king 0001→55, empty→39, rook 0101→47, empty→63 → four writes in slot order, done at T+5.
- Same cycle init_req = 1 and cmd_valid = 1 in IDLE → cmd_ready = 0, INIT runs. Then assert init_req mid-MOVE → the move completes, done pulses, and INIT starts the next cycle.
- Edge counts:
  - count 0 → no write, done at T+1
  - count 7 → clamped to 4 writes
  - duplicate addr 10 in slots 0 and 1 → both writes issued, slot 1 issued last
- Reset asserted in the middle of INIT (square 30) → change_piece = 0 while reset is high; after release, INIT restarts at square 0.
